bus_arb_4: RTL and testbench
============================

# bus_arb_4

Round-robin arbiter and sequencer for the shared 16-bit datapath built on the 4-input select mux. Four requesters (e.g. ALU result, memory read, immediate path, PC path) each present a request line and a 16-bit word. The block grants one requester at a time for a bounded burst and drives the 2-bit mux select. It registers the selected word onto the shared bus with a valid strobe, guaranteeing fair access and one-hot grants.

## Interface
- `MAX_HOLD`, default 4: maximum beats per grant, legal range 1..15.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  request lines; `req[i]` high means requester i has a word on `d_i`.
- `d0`, `d1`, `d2`, `d3`  in  16 each  requester data words.
- `gnt`  out  4  one-hot grant, registered.
- `sel`  out  2  mux select; equals index of the granted requester, registered.
- `bus_valid`  out  1  high for one cycle per transferred beat, registered.
- `bus_data`  out  16  word transferred, registered.
- `busy`  out  1  high while in GRANT state.

## Operation
- Reset values: state IDLE, `gnt`=0000, `sel`=0, `bus_valid`=0, `bus_data`=0, `busy`=0, round-robin pointer `ptr`=0, beat count=0.
- Reset overrides everything, including mid-burst. No beat completes in the reset cycle. The next arbitration starts from `ptr`=0.
- IDLE:
  - If `req`==0, stay in IDLE. `gnt`=0 and `busy`=0.
  - Otherwise pick the first i with `req[i]`=1, searching `ptr`, `ptr`+1, … mod 4.
  - Next cycle: `gnt`=1<<i, `sel`=i, `busy`=1, count=0, state GRANT.
- GRANT, with granted index g:
  - Beat: if `req[g]`=1, transfer one beat. Next cycle `bus_valid`=1 and `bus_data`=`d_g` sampled this cycle. Count increments; 4-bit counter, no wrap within the legal range.
  - Release on drop: if `req[g]`=0, no beat occurs. Release.
  - Release on limit: if the beat just taken makes count == `MAX_HOLD`, release after that beat.
  - Release action: next cycle `gnt`=0, `busy`=0, state IDLE, `ptr`=(g+1) mod 4 (2-bit wrap: 3 becomes 0).
- Requests from non-granted requesters are ignored during GRANT and are not latched. They compete at the next IDLE cycle.
- `bus_valid` is low in every cycle not following a beat. `bus_data` holds its last value when `bus_valid`=0.
- `gnt` is never more than one-hot. `sel` changes only on entry to GRANT and holds its value through IDLE.
- Simultaneous events:
  - If a requester drops `req` in the same cycle it would be granted, arbitration already happened; it receives a zero-beat grant and releases next cycle.
  - If `req[g]` drops on the same cycle count would reach the limit, no beat occurs; release as a drop.

## Timing
- Request to grant: `req[i]` rising at IDLE cycle N gives `gnt[i]` and `sel`=i at N+1.
- First beat sampled at N+1. First `bus_valid` at N+2.
- Data latency: `d_g` sampled at cycle k appears on `bus_data` at k+1.
- Burst of B beats, B ≤ `MAX_HOLD`, with request held: beats at N+1..N+B.
  - If B == `MAX_HOLD`: IDLE at N+B+1, next grant at N+B+2.
  - If released by drop at N+B+1: IDLE at N+B+2.
- Minimum one IDLE bubble between consecutive grants. Worst-case wait for a continuously requesting master is 3·(`MAX_HOLD`+2) cycles.
- No combinational path from inputs to outputs.

## Test plan
- Reset: assert `reset` for 2 cycles with `req`=1111. Then `gnt`=0000, `sel`=0, `bus_valid`=0, `bus_data`=0. Release reset. Requester 0 is granted first.
- Single burst: `req`=0010 held, `d1`=16'h00A5, `MAX_HOLD`=4. Then `gnt`=0010 for exactly 4 cycles and 4 `bus_valid` pulses, each with `bus_data`=00A5. IDLE for 1 cycle, then re-grant to requester 1.
- Round-robin fairness: `req`=1111 held, `d0..d3`=1,2,3,4. Grant order is 0,1,2,3,0. `bus_data` bursts read 1×4, 2×4, 3×4, 4×4. Pointer wraps from 3 to 0.
- Early release: grant requester 2, drop `req[2]` after 2 beats with `d2`=3. Exactly 2 `bus_valid` pulses with value 3. `gnt`=0 the cycle after the drop. The next grant goes to requester 3 if it is requesting.
- Zero-beat grant: `req`=0001 for one cycle only. `gnt`=0001 for one cycle, no `bus_valid`, return to IDLE, `ptr`=1.
- Reset mid-burst: `reset` asserted in the 2nd beat of a requester-3 burst. Next cycle all outputs are at reset values and no further `bus_valid` pulses occur. The next grant is searched from `ptr`=0.

Source files
------------

// File: rtl/bus_arb_4.sv
// Round-robin arbiter for four requesters sharing one 16-bit bus.
// Grants one requester at a time for a burst of at most MAX_HOLD beats and registers each beat onto the bus.
module bus_arb_4 #(
    parameter int MAX_HOLD = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  req,
    input  logic [15:0] d0,
    input  logic [15:0] d1,
    input  logic [15:0] d2,
    input  logic [15:0] d3,
    output logic [3:0]  gnt,
    output logic [1:0]  sel,
    output logic        bus_valid,
    output logic [15:0] bus_data,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD);

    state_t      state;
    logic [1:0]  ptr;
    logic [3:0]  count;
    logic [1:0]  pick;
    logic [1:0]  cand;
    logic [15:0] sel_data;
    logic        req_g;
    logic        last_beat;

    // Walk the candidates from the farthest offset back to ptr so the nearest requester wins.
    always_comb begin
        pick = ptr;
        cand = ptr;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        case (sel)
            2'd0:    sel_data = d0;
            2'd1:    sel_data = d1;
            2'd2:    sel_data = d2;
            default: sel_data = d3;
        endcase
    end

    assign req_g     = req[sel];
    assign last_beat = (count + 4'd1) == HOLD_LIMIT;

    // A dropped request or a beat reaching the limit both release; a drop wins when they coincide.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= 4'b0000;
            sel       <= 2'd0;
            bus_valid <= 1'b0;
            bus_data  <= 16'h0000;
            busy      <= 1'b0;
            ptr       <= 2'd0;
            count     <= 4'd0;
        end else begin
            bus_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        state <= GRANT;
                        gnt   <= 4'b0001 << pick;
                        sel   <= pick;
                        busy  <= 1'b1;
                        count <= 4'd0;
                    end else begin
                        gnt  <= 4'b0000;
                        busy <= 1'b0;
                    end
                end
                GRANT: begin
                    if (req_g) begin
                        bus_valid <= 1'b1;
                        bus_data  <= sel_data;
                        count     <= count + 4'd1;
                    end
                    if (!req_g || last_beat) begin
                        state <= IDLE;
                        gnt   <= 4'b0000;
                        busy  <= 1'b0;
                        ptr   <= sel + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arb_4.sv
// Self-checking bench for bus_arb_4: directed scenarios plus randomized traffic
// compared against a behavioural model built from the arbitration rules.
module tb_bus_arb_4;

    localparam int HOLD = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] d0, d1, d2, d3;
    logic [3:0]  gnt;
    logic [1:0]  sel;
    logic        bus_valid;
    logic [15:0] bus_data;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state: owner is -1 when nobody holds the bus.
    int          owner;
    int          nextStart;
    int          beatsTaken;
    logic [3:0]  mGnt;
    logic [1:0]  mSel;
    logic        mValid;
    logic [15:0] mData;
    logic        mBusy;

    bus_arb_4 #(.MAX_HOLD(HOLD)) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .d0(d0),
        .d1(d1),
        .d2(d2),
        .d3(d3),
        .gnt(gnt),
        .sel(sel),
        .bus_valid(bus_valid),
        .bus_data(bus_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] wordOf(input int i);
        case (i)
            0:       return d0;
            1:       return d1;
            2:       return d2;
            default: return d3;
        endcase
    endfunction

    function automatic logic [23:0] expVec();
        return {mGnt, mSel, mValid, mData, mBusy};
    endfunction

    function automatic logic [23:0] dutVec();
        return {gnt, sel, bus_valid, bus_data, busy};
    endfunction

    // Advance the model by one clock using the inputs that were just sampled.
    task automatic modelStep(input bit r, input logic [3:0] q);
        if (r) begin
            owner = -1; nextStart = 0; beatsTaken = 0;
            mGnt = 4'b0000; mSel = 2'd0; mValid = 1'b0; mData = 16'h0000; mBusy = 1'b0;
        end else if (owner < 0) begin
            mValid = 1'b0;
            mGnt   = 4'b0000;
            mBusy  = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (owner < 0 && q[(nextStart + k) % 4]) begin
                    owner = (nextStart + k) % 4;
                end
            end
            if (owner >= 0) begin
                mGnt = 4'(1 << owner);
                mSel = 2'(owner);
                mBusy = 1'b1;
                beatsTaken = 0;
            end
        end else begin
            mValid = 1'b0;
            if (q[owner]) begin
                mValid = 1'b1;
                mData  = wordOf(owner);
                beatsTaken++;
            end
            if (!q[owner] || beatsTaken == HOLD) begin
                nextStart = (owner + 1) % 4;
                owner = -1;
                mGnt  = 4'b0000;
                mBusy = 1'b0;
            end
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [3:0] q);
        reset = r;
        req   = q;
        @(posedge clk);
        modelStep(r, q);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b1, 4'b1111);
        end
        checks++;
        if (dutVec() !== 24'h0 || dutVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL reset_values got=%h want=%h", dutVec(), expVec());
        end
        applyStimulus(1'b0, 4'b1111);
        checks++;
        if (gnt !== 4'b0001 || sel !== 2'd0) begin
            failures++;
            $display("[TB] FAIL reset_first_grant got gnt=%b sel=%0d want gnt=0001 sel=0", gnt, sel);
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_single_burst();
        int gntCycles = 0;
        int pulses = 0;
        d1 = 16'h00A5;
        for (int c = 1; c <= 6; c++) begin
            applyStimulus(1'b0, 4'b0010);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL single_burst_cycle%0d got=%h want=%h", c, dutVec(), expVec());
            end
            if (c <= 5 && gnt === 4'b0010) gntCycles++;
            if (bus_valid === 1'b1) begin
                pulses++;
                checks++;
                if (bus_data !== 16'h00A5) begin
                    failures++;
                    $display("[TB] FAIL single_burst_data got=%h want=00a5", bus_data);
                end
            end
        end
        checks++;
        if (gntCycles != 4 || pulses != 4 || gnt !== 4'b0010) begin
            failures++;
            $display("[TB] FAIL single_burst_shape got grants=%0d pulses=%0d regrant=%b want 4 4 0010",
                     gntCycles, pulses, gnt);
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_round_robin();
        int order[$];
        logic [15:0] seen[$];
        logic [3:0] prevGnt;
        d0 = 16'd1; d1 = 16'd2; d2 = 16'd3; d3 = 16'd4;
        prevGnt = gnt;
        for (int c = 1; c <= 22; c++) begin
            applyStimulus(1'b0, 4'b1111);
            checks++;
            if (dutVec() !== expVec()) begin
                failures++;
                $display("[TB] FAIL round_robin_cycle%0d got=%h want=%h", c, dutVec(), expVec());
            end
            if (prevGnt == 4'b0000 && gnt != 4'b0000) order.push_back(int'(sel));
            if (bus_valid === 1'b1) seen.push_back(bus_data);
            prevGnt = gnt;
        end
        checks++;
        if (order.size() < 5 || order[0] != 0 || order[1] != 1 || order[2] != 2 || order[3] != 3 || order[4] != 0) begin
            failures++;
            $display("[TB] FAIL round_robin_order got=%p want 0 1 2 3 0", order);
        end
        checks++;
        if (seen.size() < 16) begin
            failures++;
            $display("[TB] FAIL round_robin_beats got=%0d want>=16", seen.size());
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (seen[i] !== 16'(i / 4 + 1)) begin
                    failures++;
                    $display("[TB] FAIL round_robin_data idx=%0d got=%0d want=%0d", i, seen[i], i / 4 + 1);
                    break;
                end
            end
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_early_release();
        int pulses = 0;
        d2 = 16'd3;
        d3 = 16'd9;
        for (int c = 1; c <= 3; c++) begin
            applyStimulus(1'b0, 4'b0100);
            if (bus_valid === 1'b1) begin
                pulses++;
                checks++;
                if (bus_data !== 16'd3) begin
                    failures++;
                    $display("[TB] FAIL early_release_data got=%0d want=3", bus_data);
                end
            end
        end
        applyStimulus(1'b0, 4'b1000);
        if (bus_valid === 1'b1) pulses++;
        checks++;
        if (gnt !== 4'b0000 || pulses != 2) begin
            failures++;
            $display("[TB] FAIL early_release_drop got gnt=%b pulses=%0d want 0000 2", gnt, pulses);
        end
        applyStimulus(1'b0, 4'b1000);
        checks++;
        if (gnt !== 4'b1000 || dutVec() !== expVec()) begin
            failures++;
            $display("[TB] FAIL early_release_next got=%h want=%h", dutVec(), expVec());
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_zero_beat();
        applyStimulus(1'b0, 4'b0001);
        checks++;
        if (gnt !== 4'b0001 || busy !== 1'b1) begin
            failures++;
            $display("[TB] FAIL zero_beat_grant got gnt=%b busy=%b want 0001 1", gnt, busy);
        end
        applyStimulus(1'b0, 4'b0000);
        checks++;
        if (gnt !== 4'b0000 || bus_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL zero_beat_release got gnt=%b valid=%b busy=%b want 0000 0 0", gnt, bus_valid, busy);
        end
        applyStimulus(1'b0, 4'b1111);
        checks++;
        if (gnt !== 4'b0010 || sel !== 2'd1) begin
            failures++;
            $display("[TB] FAIL zero_beat_ptr got gnt=%b sel=%0d want 0010 1", gnt, sel);
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_reset_mid_burst();
        int pulses = 0;
        d3 = 16'h3333;
        applyStimulus(1'b0, 4'b1000);
        applyStimulus(1'b0, 4'b1000);
        applyStimulus(1'b1, 4'b1000);
        checks++;
        if (dutVec() !== 24'h0) begin
            failures++;
            $display("[TB] FAIL reset_mid_values got=%h want=000000", dutVec());
        end
        for (int c = 0; c < 3; c++) begin
            applyStimulus(1'b0, 4'b0000);
            if (bus_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("[TB] FAIL reset_mid_pulses got=%0d want=0", pulses);
        end
        applyStimulus(1'b0, 4'b1001);
        checks++;
        if (gnt !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL reset_mid_ptr got gnt=%b want 0001", gnt);
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    task automatic test_random();
        logic [3:0] q = 4'b0000;
        bit r;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3, 0) == 0) q = 4'($urandom_range(15, 0));
            r  = ($urandom_range(63, 0) == 0);
            d0 = 16'($urandom); d1 = 16'($urandom);
            d2 = 16'($urandom); d3 = 16'($urandom);
            applyStimulus(r, q);
            checks++;
            if (dutVec() !== expVec() || !$onehot0(gnt)) begin
                failures++;
                $display("[TB] FAIL random_cycle%0d got=%h want=%h", c, dutVec(), expVec());
            end
        end
        applyStimulus(1'b1, 4'b0000);
    endtask

    initial begin
        reset = 1'b1;
        req   = 4'b0000;
        d0 = 16'h0; d1 = 16'h0; d2 = 16'h0; d3 = 16'h0;
        owner = -1; nextStart = 0; beatsTaken = 0;
        mGnt = 4'b0000; mSel = 2'd0; mValid = 1'b0; mData = 16'h0; mBusy = 1'b0;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_early_release();
        test_zero_beat();
        test_reset_mid_burst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
